// File: rtl/sr_flip_flop_pkg.sv
// rtl/sr_flip_flop_pkg.sv - illegal-input policy encodings and SR next-state function
package sr_flip_flop_pkg;

  typedef enum logic [1:0] {
    INV_HOLD = 2'd0,
    INV_CLR  = 2'd1,
    INV_SET  = 2'd2,
    INV_TGL  = 2'd3
  } inv_mode_e;

  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input inv_mode_e mode);
    logic nxt;
    nxt = q;
    unique case ({s, r})
      2'b00: nxt = q;
      2'b01: nxt = 1'b0;
      2'b10: nxt = 1'b1;
      default: begin
        unique case (mode)
          INV_HOLD: nxt = q;
          INV_CLR:  nxt = 1'b0;
          INV_SET:  nxt = 1'b1;
          default:  nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_flip_flop_if.sv
// rtl/sr_flip_flop_if.sv - SR bank bus: set/reset requests in, state and diagnostic out
interface sr_flip_flop_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             invalid;

  modport master (output s, r, input q, qbar, invalid);
  modport slave  (input s, r, output q, qbar, invalid);
endinterface

// File: rtl/sr_bit_cell.sv
// rtl/sr_bit_cell.sv - one SR bit: state register plus next-state logic
module sr_bit_cell
  import sr_flip_flop_pkg::*;
#(
  parameter inv_mode_e MODE        = INV_HOLD,
  parameter logic      RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic qbar_o,
  output logic illegal_o
);

  logic q_q;
  logic q_d;

  assign q_d = sr_next(s_i, r_i, q_q, MODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RESET_VALUE;
    else        q_q <= q_d;
  end

  // qbar comes off the same register so it can never agree with q
  assign q_o       = q_q;
  assign qbar_o    = ~q_q;
  assign illegal_o = s_i & r_i;

endmodule

// File: rtl/sr_flip_flop_core.sv
// rtl/sr_flip_flop_core.sv - WIDTH bit cells plus the sticky illegal-input flag
module sr_flip_flop_core
  import sr_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH        = 1,
  parameter int unsigned      INVALID_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  sr_flip_flop_if.slave   bus
);

  localparam inv_mode_e MODE = inv_mode_e'(INVALID_MODE[1:0]);

  logic [WIDTH-1:0] illegal;
  logic             invalid_q;
  logic             invalid_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit_cell #(
      .MODE        (MODE),
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_i       (bus.s[i]),
      .r_i       (bus.r[i]),
      .q_o       (bus.q[i]),
      .qbar_o    (bus.qbar[i]),
      .illegal_o (illegal[i])
    );
  end

  // only reset clears the flag
  assign invalid_d = invalid_q | (|illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) invalid_q <= 1'b0;
    else        invalid_q <= invalid_d;
  end

  assign bus.invalid = invalid_q;

endmodule

// File: rtl/sr_flip_flop.sv
// rtl/sr_flip_flop.sv - clocked SR flip-flop bank with legacy positional port order
module sr_flip_flop #(
  parameter int unsigned      WIDTH        = 1,
  parameter int unsigned      INVALID_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             invalid
);

  sr_flip_flop_if #(.WIDTH(WIDTH)) u_bus ();

  assign u_bus.s = s;
  assign u_bus.r = r;
  assign q       = u_bus.q;
  assign qbar    = u_bus.qbar;
  assign invalid = u_bus.invalid;

  sr_flip_flop_core #(
    .WIDTH        (WIDTH),
    .INVALID_MODE (INVALID_MODE),
    .RESET_VALUE  (RESET_VALUE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst),
    .bus   (u_bus.slave)
  );

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb/tb_sr_flip_flop.sv - scoreboard bench: four 1-bit policy instances plus a 4-bit bank
module tb_sr_flip_flop;

  typedef struct {
    string      name;
    logic [3:0] qm;
    logic [3:0] q4;
    logic       inv1;
    logic       inv4;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_flip_flop_if #(.WIDTH(1)) bus0 ();

  logic       q1, q2, q3, qb1, qb2, qb3, iv1, iv2, iv3;
  logic [3:0] s4, r4, q4, qbar4;
  logic       inv4;

  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (
    .s(bus0.s), .r(bus0.r), .clk(clk), .rst(rst),
    .q(bus0.q), .qbar(bus0.qbar), .invalid(bus0.invalid));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (
    .s(bus0.s), .r(bus0.r), .clk(clk), .rst(rst), .q(q1), .qbar(qb1), .invalid(iv1));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (
    .s(bus0.s), .r(bus0.r), .clk(clk), .rst(rst), .q(q2), .qbar(qb2), .invalid(iv2));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(3)) u_m3 (
    .s(bus0.s), .r(bus0.r), .clk(clk), .rst(rst), .q(q3), .qbar(qb3), .invalid(iv3));
  sr_flip_flop #(.WIDTH(4), .INVALID_MODE(0)) u_w4 (
    .s(s4), .r(r4), .clk(clk), .rst(rst), .q(q4), .qbar(qbar4), .invalid(inv4));

  exp_t sb[$];
  event chk_now;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string what, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%b required=%b at %0t", nm, what, act, exp, $time);
    end
  endtask

  // monitor: one expectation per falling edge, or on demand for mid-cycle checks
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "q_modes",    {q3, q2, q1, bus0.q},        e.qm);
        chk(e.name, "qbar_modes", {qb3, qb2, qb1, bus0.qbar},  ~e.qm);
        chk(e.name, "inv_modes",  {iv3, iv2, iv1, bus0.invalid}, {4{e.inv1}});
        chk(e.name, "q_w4",       q4,                          e.q4);
        chk(e.name, "qbar_w4",    qbar4,                       ~e.q4);
        chk(e.name, "inv_w4",     {3'b000, inv4},              {3'b000, e.inv4});
      end
    end
  end

  task automatic push(input string nm, input logic [3:0] qm, input logic [3:0] q4e,
                      input logic inv1, input logic inv4e);
    exp_t e;
    e.name = nm; e.qm = qm; e.q4 = q4e; e.inv1 = inv1; e.inv4 = inv4e;
    sb.push_back(e);
  endtask

  // drive just after a falling edge; expectation describes state after the next rising edge
  task automatic cyc(input string nm, input logic sv, input logic rv,
                     input logic [3:0] s4v, input logic [3:0] r4v,
                     input logic [3:0] qm, input logic [3:0] q4e,
                     input logic inv1, input logic inv4e);
    @(negedge clk);
    #1;
    bus0.s = sv; bus0.r = rv; s4 = s4v; r4 = r4v;
    push(nm, qm, q4e, inv1, inv4e);
  endtask

  task automatic now_chk(input string nm, input logic [3:0] qm, input logic [3:0] q4e,
                         input logic inv1, input logic inv4e);
    push(nm, qm, q4e, inv1, inv4e);
    ->chk_now;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus0.s = 1'b1; bus0.r = 1'b1; s4 = 4'hF; r4 = 4'hF;

    cyc("reset",    1, 1, 4'hF, 4'hF, 4'b0000, 4'b0000, 0, 0);
    cyc("hold0",    0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0);
    rst = 1'b1;
    cyc("clr",      0, 1, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0);
    cyc("set",      1, 0, 4'h0, 4'h0, 4'b1111, 4'b0000, 0, 0);
    cyc("hold1",    0, 0, 4'h0, 4'h0, 4'b1111, 4'b0000, 0, 0);
    cyc("illegal",  1, 1, 4'b0101, 4'b0011, 4'b0101, 4'b0100, 1, 1);
    cyc("illegal2", 1, 1, 4'h0, 4'h0, 4'b1101, 4'b0100, 1, 1);
    for (int i = 0; i < 3; i++)
      cyc("sticky", 1, 0, 4'h0, 4'h0, 4'b1111, 4'b0100, 1, 1);

    // change on the falling edge must wait for the rising edge
    @(negedge clk);
    #1;
    bus0.s = 1'b0; bus0.r = 1'b1;
    #1;
    now_chk("fall_hold", 4'b1111, 4'b0100, 1, 1);
    push("fall_clr", 4'b0000, 4'b0100, 1, 1);
    cyc("reset_prep", 1, 0, 4'h0, 4'h0, 4'b1111, 4'b0100, 1, 1);

    // asynchronous reset between edges
    @(negedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    now_chk("mid_reset", 4'b0000, 4'b0000, 0, 0);
    cyc("held_reset", 1, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0);

    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    now_chk("release", 4'b0000, 4'b0000, 0, 0);
    cyc("after_rel", 1, 0, 4'h0, 4'h0, 4'b1111, 4'b0000, 0, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
